load_store_unit: RTL and testbench

//  Sits directly upstream of the byte-wide data memory. Accepts one core load/store
//  (byte/half/word) over a valid/ready handshake and serialises it into byte accesses.

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_extend.sv | 24 ++
 rtl/load_store_unit.sv | 128 ++++++++++++
 tb/tb_load_store_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   SZ_*    : request size encodings carried on req_size
//   state_t : control FSM states
//   nbytes  : number of byte beats an access of a given size needs
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    // The illegal encoding reports 4 so downstream arithmetic stays well defined;
    // such a request is flagged as an error before any beat is issued.
    function automatic logic [2:0] nbytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: nbytes = 3'd1;
            SZ_HALF: nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Width and sign extension of the collected load lanes.
//   lanes       in  32  {lane3, lane2, lane1, lane0}, little-endian bytes
//   size        in  2   access size encoding
//   is_unsigned in  1   1 = zero-extend, 0 = sign-extend
//   data        out 32  extended result
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [31:0] lanes,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    always_comb begin
        data = lanes;
        case (size)
            SZ_BYTE: data = {{24{~is_unsigned & lanes[7]}},  lanes[7:0]};
            SZ_HALF: data = {{16{~is_unsigned & lanes[15]}}, lanes[15:0]};
            default: data = lanes;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Serialises one core load/store (byte/half/word) into byte accesses on a
// byte-wide data memory and returns extended load data with a one-cycle pulse.
//   clk, reset            clock and synchronous active-low reset
//   req_*                 core request, valid/ready handshake (ready only in IDLE)
//   resp_valid/rdata/error one-cycle completion with extended data or error flag
//   busy                  high whenever the FSM is not IDLE
//   mem_*                 byte-wide memory port, active only during XFER
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES   = 32,
    parameter int CHECK_ALIGN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [7:0]  mem_rdata
);

    state_t          state;
    logic [1:0]      count;
    logic [3:0][7:0] lanes;
    logic [3:0][7:0] wdata_q;
    logic [31:0]     addr_q;
    logic [1:0]      size_q;
    logic            write_q;
    logic            unsigned_q;
    logic            err_q;

    logic [2:0]  req_n;
    logic [32:0] req_end;
    logic        req_misaligned;
    logic        req_err;
    logic        last_beat;
    logic        is_xfer;
    logic [31:0] ext_data;

    // Range check in 33 bits so an address near 2^32 cannot wrap back into range.
    assign req_n          = nbytes(req_size);
    assign req_end        = {1'b0, req_addr} + {30'b0, req_n};
    assign req_misaligned = (CHECK_ALIGN != 0) &&
                            ((req_addr[1:0] & (req_n[1:0] - 2'd1)) != 2'b00);
    assign req_err        = (req_size == SZ_ILL) || req_misaligned ||
                            (req_end > 33'(MEM_BYTES));

    assign last_beat = ({1'b0, count} == (nbytes(size_q) - 3'd1));
    assign is_xfer   = (state == XFER);

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    assign mem_addr  = is_xfer ? (addr_q + {30'b0, count}) : '0;
    assign mem_read  = is_xfer & ~write_q;
    assign mem_write = is_xfer &  write_q;
    assign mem_wdata = (is_xfer & write_q) ? wdata_q[count] : '0;

    lsu_extend u_extend (
        .lanes       (lanes),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .data        (ext_data)
    );

    assign resp_valid = (state == RESP);
    assign resp_error = resp_valid & err_q;
    assign resp_rdata = (resp_valid & ~write_q & ~err_q) ? ext_data : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            lanes      <= '0;
            wdata_q    <= '0;
            addr_q     <= '0;
            size_q     <= '0;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q    <= req_write;
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        lanes      <= '0;
                        count      <= '0;
                        err_q      <= req_err;
                        state      <= req_err ? RESP : XFER;
                    end
                end
                XFER: begin
                    if (!write_q) begin
                        lanes[count] <= mem_rdata;
                    end
                    if (last_beat) begin
                        state <= RESP;
                    end else begin
                        count <= count + 2'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        busy;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [7:0]  mem_rdata;

    logic [7:0] tb_mem [32];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(32), .CHECK_ALIGN(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .busy         (busy),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .mem_rdata    (mem_rdata)
    );

    // Byte-wide memory: combinational read, write captured on posedge.
    assign mem_rdata = tb_mem[mem_addr[4:0]];
    always @(posedge clk) begin
        if (mem_write) tb_mem[mem_addr[4:0]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request and follow it to completion, checking latency, every
    // memory beat, busy, and the response contents.
    task automatic do_req(input string tag, input logic w, input logic [1:0] sz,
                          input logic u, input logic [31:0] a, input logic [31:0] wd,
                          input int exp_lat, input logic [31:0] exp_rd, input logic exp_err);
        int          lat;
        int          nacc;
        int          exp_nacc;
        logic [31:0] rd;
        logic        er;
        logic [31:0] sh;
        lat  = 0;
        nacc = 0;
        rd   = '0;
        er   = 1'b0;
        exp_nacc = exp_err ? 0 : (sz == 2'b00 ? 1 : (sz == 2'b01 ? 2 : 4));
        @(negedge clk);
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        check({tag, " ready"}, {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            check({tag, " rd_wr_excl"}, {31'b0, mem_read & mem_write}, 32'd0);
            if (mem_read || mem_write) begin
                check({tag, " mem_addr"}, mem_addr, a + 32'(nacc));
                check({tag, " mem_dir"}, {31'b0, mem_write}, {31'b0, w});
                if (w) begin
                    sh = wd >> (8 * nacc);
                    check({tag, " mem_wdata"}, {24'b0, mem_wdata}, {24'b0, sh[7:0]});
                end
                nacc++;
            end
            if (resp_valid) begin
                lat = k;
                rd  = resp_rdata;
                er  = resp_error;
            end else begin
                check({tag, " busy"}, {31'b0, busy}, 32'd1);
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " rdata"}, rd, exp_rd);
        check({tag, " error"}, {31'b0, er}, {31'b0, exp_err});
        check({tag, " beats"}, 32'(nacc), 32'(exp_nacc));
        @(negedge clk);
        check({tag, " pulse"}, {31'b0, resp_valid}, 32'd0);
        check({tag, " idle"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        logic [5:0] rdy_pat;
        logic [5:0] rsp_pat;
        int         wr_after_rst;

        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = '0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst busy", {31'b0, busy}, 32'd0);
        check("rst resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst mem_write", {31'b0, mem_write}, 32'd0);
        check("rst mem_read", {31'b0, mem_read}, 32'd0);
        reset = 1'b1;

        // 1: reset mid word store abandons the transfer
        @(negedge clk);
        req_write = 1'b1; req_size = 2'b10; req_addr = 32'h10; req_wdata = 32'h11223344;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("t1 first beat", {31'b0, mem_write}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        wr_after_rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_write || resp_valid) wr_after_rst++;
        end
        reset = 1'b1;
        @(negedge clk);
        check("t1 no strobe after reset", 32'(wr_after_rst), 32'd0);
        check("t1 ready after release", {31'b0, req_ready}, 32'd1);
        check("t1 quiet after release", {30'b0, mem_write, resp_valid}, 32'd0);

        // 2: store word
        do_req("t2 st_w", 1'b1, 2'b10, 1'b0, 32'h08, 32'hA1B2C3D4, 5, 32'h0, 1'b0);
        // 3: load byte signed/unsigned
        do_req("t3 ld_b_s", 1'b0, 2'b00, 1'b0, 32'h0B, 32'h0, 2, 32'hFFFFFFA1, 1'b0);
        do_req("t3 ld_b_u", 1'b0, 2'b00, 1'b1, 32'h0B, 32'h0, 2, 32'h000000A1, 1'b0);
        // 4: load half / word
        do_req("t4 ld_h_s", 1'b0, 2'b01, 1'b0, 32'h08, 32'h0, 3, 32'hFFFFC3D4, 1'b0);
        do_req("t4 ld_h_u", 1'b0, 2'b01, 1'b1, 32'h0A, 32'h0, 3, 32'h0000A1B2, 1'b0);
        do_req("t4 ld_w", 1'b0, 2'b10, 1'b1, 32'h08, 32'h0, 5, 32'hA1B2C3D4, 1'b0);
        // 5: errors and range boundary
        do_req("t5 ld_w_mis", 1'b0, 2'b10, 1'b0, 32'h0A, 32'h0, 1, 32'h0, 1'b1);
        do_req("t5 ld_b_oor", 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 1, 32'h0, 1'b1);
        do_req("t5 ld_b_wrap", 1'b0, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h0, 1, 32'h0, 1'b1);
        do_req("t5 ld_h_mis", 1'b0, 2'b01, 1'b0, 32'h1F, 32'h0, 1, 32'h0, 1'b1);
        do_req("t5 st_w_oor", 1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678, 1, 32'h0, 1'b1);
        do_req("t5 st_b_last", 1'b1, 2'b00, 1'b0, 32'h1F, 32'hFFFFFF85, 2, 32'h0, 1'b0);
        do_req("t5 ld_b_last", 1'b0, 2'b00, 1'b0, 32'h1F, 32'h0, 2, 32'hFFFFFF85, 1'b0);
        // 6: illegal size, then back-to-back with valid held
        do_req("t6 size_ill", 1'b0, 2'b11, 1'b0, 32'h08, 32'h0, 1, 32'h0, 1'b1);

        rdy_pat = 6'b001001;   // bit i = expected req_ready in cycle i
        rsp_pat = 6'b100100;   // bit i = expected resp_valid in cycle i
        @(negedge clk);
        req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h0B;
        req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("t6 b2b ready c%0d", i), {31'b0, req_ready}, {31'b0, rdy_pat[i]});
            check($sformatf("t6 b2b resp c%0d", i), {31'b0, resp_valid}, {31'b0, rsp_pat[i]});
            if (rsp_pat[i]) check($sformatf("t6 b2b rdata c%0d", i), resp_rdata, 32'hFFFFFFA1);
        end
        req_valid = 1'b0;
        @(negedge clk);
        check("t6 b2b idle", {31'b0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
